// File: rtl/ddr2_v11_0_p0_qsys_sequencer_ram_arbiter_if.sv
// Avalon-MM style requester port into the sequencer RAM arbiter.
// master drives the request side; slave returns wait/read data.
interface ddr2_v11_0_p0_qsys_sequencer_ram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ddr2_v11_0_p0_qsys_sequencer_ram_arbiter.sv
// Round-robin 2:1 arbiter for the sequencer 512x32 sync-read RAM.
// SEQ_RAM_ARB_SCRUB_EN adds a post-reset zero-fill of the whole RAM.
module ddr2_v11_0_p0_qsys_sequencer_ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  ddr2_v11_0_p0_qsys_sequencer_ram_arbiter_if.slave m0,
  ddr2_v11_0_p0_qsys_sequencer_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [CNT_W-1:0]  contention_count,
  output logic              scrub_busy
);

  logic              req0, req1;
  logic              rd0, rd1;
  logic              grant0, grant1;
  logic              scrub_act;
  logic [ADDR_W-1:0] scrub_addr;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef SEQ_RAM_ARB_SCRUB_EN
  typedef enum logic {S_SCRUB, S_RUN} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SCRUB;
      scrub_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    scrub_addr_d = scrub_addr_q;
    unique case (state_q)
      S_SCRUB: begin
        scrub_addr_d = scrub_addr_q + 1'b1;
        if (&scrub_addr_q) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  assign scrub_act  = (state_q == S_SCRUB) & ~reset;
  assign scrub_addr = scrub_addr_q;
`else
  assign scrub_act  = 1'b0;
  assign scrub_addr = '0;
`endif

  // read+write together counts as a write only
  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;
  assign rd0  = m0.read & ~m0.write;
  assign rd1  = m1.read & ~m1.write;

  always_comb begin
    grant0       = 1'b0;
    grant1       = 1'b0;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if (!reset && !scrub_act) begin
      grant0 = req0 & (~req1 | last_grant_q);
      grant1 = req1 & ~grant0;
    end
    if (grant0)      last_grant_d = 1'b0;
    else if (grant1) last_grant_d = 1'b1;
    rd_pend_d = {grant1 & rd1, grant0 & rd0};
    if (req0 && req1 && !scrub_act && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    unique case (1'b1)
      scrub_act: begin
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        ram_address    = scrub_addr;
        ram_byteenable = '1;
      end
      grant0: begin
        ram_chipselect = 1'b1;
        ram_write      = m0.write;
        ram_address    = m0.address;
        ram_byteenable = m0.byteenable;
        ram_writedata  = m0.writedata;
      end
      grant1: begin
        ram_chipselect = 1'b1;
        ram_write      = m1.write;
        ram_address    = m1.address;
        ram_byteenable = m1.byteenable;
        ram_writedata  = m1.writedata;
      end
      default: ;
    endcase
  end

  // reset squashes a strobe already in flight
  assign m0.readdatavalid = rd_pend_q[0] & ~reset;
  assign m1.readdatavalid = rd_pend_q[1] & ~reset;
  assign m0.readdata      = m0.readdatavalid ? ram_readdata : '0;
  assign m1.readdata      = m1.readdatavalid ? ram_readdata : '0;
  assign m0.waitrequest   = ~grant0;
  assign m1.waitrequest   = ~grant1;

  assign ram_clken        = 1'b1;
  assign contention_count = cnt_q;
  assign scrub_busy       = scrub_act;

endmodule

// File: tb/tb_ddr2_v11_0_p0_qsys_sequencer_ram_arbiter.sv
// Scoreboard bench: random/directed requests on both ports against a
// behavioural memory + round-robin model; monitor checks read returns.
module tb_ddr2_v11_0_p0_qsys_sequencer_ram_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 16;
`ifdef SEQ_RAM_ARB_SCRUB_EN
  localparam int SCRUB_N = 512;
`else
  localparam int SCRUB_N = 0;
`endif

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr2_v11_0_p0_qsys_sequencer_ram_arbiter_if #(AW, DW, BW) m0_if ();
  ddr2_v11_0_p0_qsys_sequencer_ram_arbiter_if #(AW, DW, BW) m1_if ();

  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic          ram_chipselect;
  logic          ram_write;
  logic [DW-1:0] ram_writedata;
  logic          ram_clken;
  logic [DW-1:0] ram_readdata;
  logic [CW-1:0] contention_count;
  logic          scrub_busy;

  ddr2_v11_0_p0_qsys_sequencer_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(rst),
    .m0(m0_if),
    .m1(m1_if),
    .ram_address(ram_address),
    .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect),
    .ram_write(ram_write),
    .ram_writedata(ram_writedata),
    .ram_clken(ram_clken),
    .ram_readdata(ram_readdata),
    .contention_count(contention_count),
    .scrub_busy(scrub_busy)
  );

  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] ad [2];
  logic [BW-1:0] be [2];
  logic [DW-1:0] wd [2];
  logic          wt [2];
  logic          rv [2];
  logic [DW-1:0] rdat [2];

  assign m0_if.read       = rd[0];
  assign m0_if.write      = wr[0];
  assign m0_if.address    = ad[0];
  assign m0_if.byteenable = be[0];
  assign m0_if.writedata  = wd[0];
  assign m1_if.read       = rd[1];
  assign m1_if.write      = wr[1];
  assign m1_if.address    = ad[1];
  assign m1_if.byteenable = be[1];
  assign m1_if.writedata  = wd[1];
  assign wt[0]   = m0_if.waitrequest;
  assign wt[1]   = m1_if.waitrequest;
  assign rv[0]   = m0_if.readdatavalid;
  assign rv[1]   = m1_if.readdatavalid;
  assign rdat[0] = m0_if.readdata;
  assign rdat[1] = m1_if.readdata;

  // Synchronous-read RAM behind the arbiter
  logic [DW-1:0] ram [512];
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < BW; b++)
          if (ram_byteenable[b])
            ram[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= ram[ram_address];
      end
    end
  end

  // Reference model state
  logic [DW-1:0] mem [512];
  int   last_g = 1;
  int   cnt_m = 0;
  int   scrub_left = 0;
  int   cyc = 0;
  exp_t expq [2][$];
  txn_t txq [2][$];
  logic busy [2];
  logic acc [2];
  logic auto_rd [2];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: arbitration, memory contents, contention count, scrub
  always @(negedge clk) begin
    logic r [2];
    logic sc;
    int   g;
    for (int m = 0; m < 2; m++) r[m] = rd[m] | wr[m];
    sc = !rst && scrub_left > 0;
    g  = -1;
    if (!rst && !sc) begin
      if (r[0] && r[1]) g = 1 - last_g;
      else if (r[0])    g = 0;
      else if (r[1])    g = 1;
    end
    chk("m0_waitrequest", wt[0], g != 0);
    chk("m1_waitrequest", wt[1], g != 1);
    chk("ram_chipselect", ram_chipselect, (g >= 0) || sc);
    chk("scrub_busy", scrub_busy, sc);
    chk("contention_count", contention_count, cnt_m);
    chk("ram_clken", ram_clken, 1);
    if (g >= 0) begin
      if (wr[g]) begin
        for (int b = 0; b < BW; b++)
          if (be[g][b]) mem[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
      end else begin
        expq[g].push_back('{mem[ad[g]], cyc + 1});
      end
      last_g = g;
    end
    for (int m = 0; m < 2; m++) acc[m] = r[m] && !wt[m];
    if (rst) begin
      last_g     = 1;
      cnt_m      = 0;
      scrub_left = SCRUB_N;
    end else if (sc) begin
      mem[SCRUB_N - scrub_left] = '0;
      scrub_left--;
    end else if (r[0] && r[1] && cnt_m < 65535) begin
      cnt_m++;
    end
  end

  // Monitor: read-return strobes and data
  always @(negedge clk) begin
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        expq[m].delete();
        chk($sformatf("m%0d_rdvalid_reset", m), rv[m], 0);
      end else if (expq[m].size() != 0 && expq[m][0].due == cyc) begin
        e = expq[m].pop_front();
        chk($sformatf("m%0d_readdatavalid", m), rv[m], 1);
        chk($sformatf("m%0d_readdata", m), rdat[m], e.data);
      end else begin
        chk($sformatf("m%0d_readdatavalid_idle", m), rv[m], 0);
        chk($sformatf("m%0d_readdata_idle", m), rdat[m], 0);
      end
    end
  end

  // Requester agents: hold each request until accepted
  initial begin
    for (int m = 0; m < 2; m++) begin
      rd[m] = 0; wr[m] = 0; ad[m] = '0; be[m] = '0; wd[m] = '0;
      busy[m] = 0; acc[m] = 0; auto_rd[m] = 0;
    end
  end

  always @(posedge clk) begin
    txn_t t;
    #1;
    for (int m = 0; m < 2; m++) begin
      if (!busy[m] || acc[m]) begin
        if (txq[m].size() != 0)
          t = txq[m].pop_front();
        else if (auto_rd[m])
          t = '{1'b1, 1'b0, AW'($urandom), 4'hF, 32'h0};
        else
          t = '{1'b0, 1'b0, '0, '0, '0};
        rd[m] = t.rd; wr[m] = t.wr; ad[m] = t.addr;
        be[m] = t.be; wd[m] = t.data;
        busy[m] = t.rd | t.wr;
      end
    end
  end

  task automatic push(int m, logic r, logic w, logic [AW-1:0] a,
                      logic [BW-1:0] b, logic [DW-1:0] d);
    txq[m].push_back('{r, w, a, b, d});
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    while ((txq[0].size() != 0 || txq[1].size() != 0 || busy[0] || busy[1] ||
            expq[0].size() != 0 || expq[1].size() != 0) && n < lim) begin
      @(posedge clk);
      n++;
    end
    n_cmp++;
    if (n >= lim) begin
      n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles", lim);
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(int n);
    @(posedge clk); #2;
    rst = 1;
    repeat (n) @(posedge clk);
    #2;
    rst = 0;
  endtask

  initial begin
    int k;
    int w;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    wait_idle(2000);

    // write then read back on m0
    push(0, 0, 1, 9'h005, 4'hF, 32'hDEADBEEF);
    push(0, 1, 0, 9'h005, 4'hF, 32'h0);
    wait_idle(100);

    // partial write at the top address
    push(1, 0, 1, 9'h1FF, 4'hF, 32'hFFFFFFFF);
    push(1, 0, 1, 9'h1FF, 4'h3, 32'h12345678);
    wait_idle(100);
    push(0, 1, 0, 9'h1FF, 4'hF, 32'h0);
    wait_idle(100);

    // contention straight out of reset: m0 takes the first tie
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      push(0, 1, 0, 9'h005, 4'hF, 32'h0);
      push(1, 1, 0, 9'h1FF, 4'hF, 32'h0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 0;
    wait_idle(3000);

    // reset lands the cycle after a read grant
    push(0, 1, 0, 9'h005, 4'hF, 32'h0);
    w = 0;
    while (!acc[0] && w < 50) begin @(negedge clk); w++; end
    n_cmp++;
    if (w >= 50) begin
      n_bad++;
      $display("FAIL mid_reset_grant: no grant within 50 cycles");
    end
    @(posedge clk); #2;
    rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    wait_idle(2000);
    push(0, 1, 0, 9'h1FF, 4'hF, 32'h0);
    push(1, 1, 0, 9'h005, 4'hF, 32'h0);
    wait_idle(100);

    // randomized traffic on both ports
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        k = $urandom_range(0, 3);
        push(m, k[0], k[1],
             ($urandom_range(0, 7) == 0) ? 9'h1FF : AW'($urandom_range(0, 15)),
             BW'($urandom), $urandom);
      end
    end
    wait_idle(5000);

`ifdef SEQ_RAM_ARB_SCRUB_EN
    push(0, 0, 1, 9'h0AA, 4'hF, 32'h00000055);
    wait_idle(100);
    rst = 1;
    push(0, 1, 0, 9'h0AA, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    wait_idle(2000);
`endif

    // saturate the contention counter
    auto_rd[0] = 1;
    auto_rd[1] = 1;
    repeat (65541) @(posedge clk);
    #2;
    auto_rd[0] = 0;
    auto_rd[1] = 0;
    wait_idle(100);
    chk("contention_saturated", contention_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
